fft_bfly_sched: RTL and testbench
=================================

// Module: fft_bfly_sched
// PURPOSE
//  Sequences one radix-2 DIT, in-place FFT pass by pass over a shared twiddle_factor
//  complex-multiplier butterfly datapath. Issues one butterfly per enabled cycle:
//  - operand A/B RAM read addresses and the twiddle ROM address;
//  - matching writeback addresses, delayed by the datapath latency.
//  Inserts a drain gap between stages so stage s+1 never reads data stage s has not yet written.
// PARAMETERS
//  N        1024  FFT points; power of two, >= 4
//  LOGN     10    log2(N); number of stages
//  PIPE_LAT 3     read-issue to writeback latency of the butterfly datapath, in enabled cycles; >= 1
// PORTS
//  clk         in   1       rising-edge clock
//  rst         in   1       synchronous, active-high reset
//  start       in   1       pulse: begin a transform; ignored unless IDLE
//  en          in   1       global advance enable; 0 freezes the whole block
//  busy        out  1       high from the cycle after start to the done cycle, exclusive
//  done        out  1       one-cycle pulse when the transform completes
//  stage       out  LOGN-w  current stage index s, 0..LOGN-1; w = clog2(LOGN)
//  rd_valid    out  1       rd_addr_a, rd_addr_b and tw_addr are valid this cycle
//  rd_addr_a   out  LOGN    upper butterfly operand address
//  rd_addr_b   out  LOGN    lower butterfly operand address
//  tw_addr     out  LOGN-1  twiddle ROM index k, selects W_N^k
//  wr_valid    out  1       wr_addr_a and wr_addr_b are valid this cycle
//  wr_addr_a   out  LOGN    writeback address for the A result
//  wr_addr_b   out  LOGN    writeback address for the B result
// BEHAVIOUR
//  - Reset: every output is 0, FSM goes to IDLE, delay line is cleared. Takes priority over
//    everything, including mid-transform; no partial writes follow a reset.
//  - FSM states: IDLE -> RUN on start. RUN -> FLUSH after the last butterfly of a stage.
//    FLUSH -> RUN (next stage) or -> DONE (after the last stage). DONE -> IDLE after 1 cycle.
//  - Butterfly counter k runs 0..N/2-1 within each stage. Read-address math, with span = 2^s:
//    - addr_a = ((k >> s) << (s+1)) | (k & (span-1))
//    - addr_b = addr_a + span
//    - tw_addr = (k & (span-1)) << (LOGN-1-s)
//    - all values are unsigned; no wrap-around can occur.
//  - Read outputs are registered. A start in IDLE at cycle t gives rd_valid at t+1 with s=0, k=0.
//  - RUN with en=1: one butterfly is issued per cycle, rd_valid=1, k increments.
//  - Writeback: a PIPE_LAT-deep delay line of {valid, addr_a, addr_b}, shifted only when en=1.
//    wr_* equals the rd_* values issued PIPE_LAT enabled cycles earlier.
//  - FLUSH: lasts exactly PIPE_LAT enabled cycles with rd_valid=0.
//    - The first read of stage s+1 comes in the enabled cycle after the last write of stage s.
//    - Each stage therefore costs N/2+PIPE_LAT enabled cycles.
//  - DONE: done=1 and busy=0 in the enabled cycle after the last wr_valid.
//    - Total length is 1 + LOGN*(N/2+PIPE_LAT) enabled cycles, counted from start.
//  - en=0: all state, counters and the delay line hold. rd_valid and wr_valid are forced to 0;
//    address outputs hold. A done pulse falling in a stalled cycle is deferred until en=1.
//  - A start while busy or in DONE is ignored. A start coinciding with rst is ignored.
//  - The stage output holds the last stage index (LOGN-1) through DONE and returns to 0 in IDLE.
// TESTING
//  - Reset: assert rst for 2 cycles mid-RUN of stage 3 -> the next cycle has every output 0, the
//    FSM in IDLE, and no wr_valid after reset is released.
//  - N=8, PIPE_LAT=3, start at t0, en=1. Stage 0 reads (a,b,tw): (0,1,0) (2,3,0) (4,5,0) (6,7,0)
//    -> stage 1 reads: (0,2,0) (1,3,2) (4,6,0) (5,7,2)
//    -> stage 2 reads: (0,4,0) (1,5,1) (2,6,2) (3,7,3)
//    -> stage starts at t0+1, t0+8 and t0+15; done at t0+22.
//  - Same config -> every wr_valid lands exactly 3 cycles after its matching rd_valid with
//    identical addresses, and there are 3 idle cycles between stages.
//  - N=1024, PIPE_LAT=3, en=1 throughout -> 5120 rd_valid and 5120 wr_valid pulses, with done at
//    t0+5151. A scoreboard shows each address written exactly once per stage.
//  - Drop en low for 5 cycles in RUN and for 2 cycles in FLUSH -> the address sequence is unchanged
//    and done is delayed by exactly 7 cycles.
//  - Pulse start at t0+50 during RUN, and again in the DONE cycle -> both are ignored, with no
//    restart and unchanged counts.

Source files
------------

// File: rtl/fft_bfly_sched.sv
// Address sequencer for an in-place radix-2 DIT FFT over one shared butterfly datapath.
// Latency: first read one cycle after start; writeback PIPE_LAT enabled cycles after each read.
// Backpressure: en=0 freezes all state; rd_valid, wr_valid and done are masked while stalled.
module fft_bfly_sched #(
  parameter int N        = 1024,
  parameter int LOGN     = 10,
  parameter int PIPE_LAT = 3,
  localparam int SW      = $clog2(LOGN),
  localparam int KW      = LOGN - 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            en,
  output logic            busy,
  output logic            done,
  output logic [SW-1:0]   stage,
  output logic            rd_valid,
  output logic [LOGN-1:0] rd_addr_a,
  output logic [LOGN-1:0] rd_addr_b,
  output logic [KW-1:0]   tw_addr,
  output logic            wr_valid,
  output logic [LOGN-1:0] wr_addr_a,
  output logic [LOGN-1:0] wr_addr_b
);

  localparam int HALF = N / 2;
  localparam int FW   = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef struct packed {
    logic [LOGN-1:0] a;
    logic [LOGN-1:0] b;
    logic [KW-1:0]   tw;
  } rd_req_t;

  logic [1:0]    state;
  logic [SW-1:0] s_q;
  logic [KW-1:0] k_q;
  logic [FW-1:0] fl_q;

  logic [LOGN-1:0] ra_q;
  logic [LOGN-1:0] rb_q;
  logic [KW-1:0]   tw_q;

  logic [PIPE_LAT-1:0]           dl_vld;
  logic [PIPE_LAT-1:0][LOGN-1:0] dl_a;
  logic [PIPE_LAT-1:0][LOGN-1:0] dl_b;

  logic          iss;
  logic [SW-1:0] iss_s;
  logic [KW-1:0] iss_k;
  rd_req_t       nxt_req;

  logic last_k;
  logic last_flush;
  logic last_stage;

  // Butterfly k of stage s: the group index (k >> s) selects a block of 2*span points,
  // the low s bits of k select the offset inside it; twiddle stride halves each stage.
  function automatic rd_req_t bfly_addr(input logic [SW-1:0] s, input logic [KW-1:0] k);
    rd_req_t         r;
    logic [LOGN-1:0] kx;
    logic [LOGN-1:0] span;
    logic [LOGN-1:0] mask;
    logic [LOGN-1:0] hi;
    logic [KW-1:0]   kt;
    kx   = {1'b0, k};
    span = LOGN'(1) << s;
    mask = span - 1'b1;
    hi   = ((kx >> s) << s) << 1;
    kt   = k & mask[KW-1:0];
    r.a  = hi | (kx & mask);
    r.b  = r.a + span;
    r.tw = kt << (KW - int'(s));
    return r;
  endfunction

  assign last_k     = (k_q == KW'(HALF - 1));
  assign last_flush = (fl_q == FW'(PIPE_LAT - 1));
  assign last_stage = (s_q == SW'(LOGN - 1));

  // Decide whether the coming enabled edge issues a butterfly, and which one.
  always_comb begin
    iss   = 1'b0;
    iss_s = s_q;
    iss_k = '0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          iss   = 1'b1;
          iss_s = '0;
        end
      end
      ST_RUN: begin
        if (!last_k) begin
          iss   = 1'b1;
          iss_k = k_q + 1'b1;
        end
      end
      ST_FLUSH: begin
        if (last_flush && !last_stage) begin
          iss   = 1'b1;
          iss_s = s_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign nxt_req = bfly_addr(iss_s, iss_k);

  // Sequencer: stage/butterfly counters and the drain gap between stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      s_q   <= '0;
      k_q   <= '0;
      fl_q  <= '0;
    end else if (en) begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_RUN;
            s_q   <= '0;
            k_q   <= '0;
          end
        end
        ST_RUN: begin
          if (last_k) begin
            state <= ST_FLUSH;
            fl_q  <= '0;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        ST_FLUSH: begin
          if (last_flush) begin
            if (last_stage) begin
              state <= ST_DONE;
            end else begin
              state <= ST_RUN;
              s_q   <= s_q + 1'b1;
              k_q   <= '0;
            end
          end else begin
            fl_q <= fl_q + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          s_q   <= '0;
        end
      endcase
    end
  end

  // Registered read request; addresses hold between issues.
  always_ff @(posedge clk) begin
    if (rst) begin
      ra_q <= '0;
      rb_q <= '0;
      tw_q <= '0;
    end else if (en && iss) begin
      ra_q <= nxt_req.a;
      rb_q <= nxt_req.b;
      tw_q <= nxt_req.tw;
    end
  end

  // Writeback delay line, advanced in lockstep with the datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      dl_vld <= '0;
      dl_a   <= '0;
      dl_b   <= '0;
    end else if (en) begin
      for (int i = PIPE_LAT - 1; i > 0; i--) begin
        dl_vld[i] <= dl_vld[i-1];
        dl_a[i]   <= dl_a[i-1];
        dl_b[i]   <= dl_b[i-1];
      end
      dl_vld[0] <= (state == ST_RUN);
      dl_a[0]   <= ra_q;
      dl_b[0]   <= rb_q;
    end
  end

  assign busy      = (state == ST_RUN) || (state == ST_FLUSH);
  assign done      = en && (state == ST_DONE);
  assign stage     = s_q;
  assign rd_valid  = en && (state == ST_RUN);
  assign rd_addr_a = ra_q;
  assign rd_addr_b = rb_q;
  assign tw_addr   = tw_q;
  assign wr_valid  = en && dl_vld[PIPE_LAT-1];
  assign wr_addr_a = dl_a[PIPE_LAT-1];
  assign wr_addr_b = dl_b[PIPE_LAT-1];

endmodule

// File: tb/tb_fft_bfly_sched.sv
// Bench for fft_bfly_sched: an 8-point and a 1024-point instance, each checked cycle by
// cycle against an event table built from the butterfly group/offset description.
// Covers reset, stalls in RUN and FLUSH, random enable, and ignored start pulses.
module tb_fft_bfly_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // small instance: N=8
  logic       s_start = 1'b0, s_en = 1'b0;
  logic       s_busy, s_done, s_rv, s_wv;
  logic [1:0] s_stage, s_tw;
  logic [2:0] s_ra, s_rb, s_wa, s_wb;

  // large instance: N=1024
  logic       b_start = 1'b0, b_en = 1'b0;
  logic       b_busy, b_done, b_rv, b_wv;
  logic [3:0] b_stage;
  logic [8:0] b_tw;
  logic [9:0] b_ra, b_rb, b_wa, b_wb;

  fft_bfly_sched #(.N(8), .LOGN(3), .PIPE_LAT(3)) u_small (
    .clk(clk), .rst(rst), .start(s_start), .en(s_en),
    .busy(s_busy), .done(s_done), .stage(s_stage),
    .rd_valid(s_rv), .rd_addr_a(s_ra), .rd_addr_b(s_rb), .tw_addr(s_tw),
    .wr_valid(s_wv), .wr_addr_a(s_wa), .wr_addr_b(s_wb)
  );

  fft_bfly_sched #(.N(1024), .LOGN(10), .PIPE_LAT(3)) u_big (
    .clk(clk), .rst(rst), .start(b_start), .en(b_en),
    .busy(b_busy), .done(b_done), .stage(b_stage),
    .rd_valid(b_rv), .rd_addr_a(b_ra), .rd_addr_b(b_rb), .tw_addr(b_tw),
    .wr_valid(b_wv), .wr_addr_a(b_wa), .wr_addr_b(b_wb)
  );

  int sel = 0;
  int m_busy, m_done, m_stage, m_rv, m_ra, m_rb, m_tw, m_wv, m_wa, m_wb;

  always_comb begin
    if (sel == 0) begin
      m_busy = int'(s_busy); m_done = int'(s_done); m_stage = int'(s_stage);
      m_rv = int'(s_rv); m_ra = int'(s_ra); m_rb = int'(s_rb); m_tw = int'(s_tw);
      m_wv = int'(s_wv); m_wa = int'(s_wa); m_wb = int'(s_wb);
    end else begin
      m_busy = int'(b_busy); m_done = int'(b_done); m_stage = int'(b_stage);
      m_rv = int'(b_rv); m_ra = int'(b_ra); m_rb = int'(b_rb); m_tw = int'(b_tw);
      m_wv = int'(b_wv); m_wa = int'(b_wa); m_wb = int'(b_wb);
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: per enabled-cycle position, what the block must show.
  int md_n, md_logn, md_p, md_h, md_total;
  int exp_rv [0:5999];
  int exp_ra [0:5999];
  int exp_rb [0:5999];
  int exp_tw [0:5999];
  int exp_wv [0:5999];
  int exp_wa [0:5999];
  int exp_wb [0:5999];
  int sb [0:9][0:1023];

  task automatic build_model(input int n, input int logn, input int p);
    md_n = n; md_logn = logn; md_p = p; md_h = n / 2;
    md_total = 1 + logn * (md_h + p);
    for (int i = 0; i < 6000; i++) begin
      exp_rv[i] = 0; exp_wv[i] = 0;
      exp_ra[i] = 0; exp_rb[i] = 0; exp_tw[i] = 0; exp_wa[i] = 0; exp_wb[i] = 0;
    end
    for (int s = 0; s < logn; s++) begin
      int span, base;
      span = 1 << s;
      base = 1 + s * (md_h + p);
      for (int g = 0; g < md_h / span; g++) begin
        for (int j = 0; j < span; j++) begin
          int i;
          i = base + g * span + j;
          exp_rv[i] = 1;
          exp_ra[i] = g * 2 * span + j;
          exp_rb[i] = g * 2 * span + j + span;
          exp_tw[i] = j * (n / (2 * span));
          exp_wv[i + p] = 1;
          exp_wa[i + p] = exp_ra[i];
          exp_wb[i + p] = exp_rb[i];
        end
      end
    end
  endtask

  task automatic drive(input logic st, input logic e);
    if (sel == 0) begin
      s_start = st; s_en = e; b_start = 1'b0; b_en = 1'b0;
    end else begin
      b_start = st; b_en = e; s_start = 1'b0; s_en = 1'b0;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, m_busy, 0);
    chk({tag, "_done"}, m_done, 0);
    chk({tag, "_stage"}, m_stage, 0);
    chk({tag, "_rv"}, m_rv, 0);
    chk({tag, "_ra"}, m_ra, 0);
    chk({tag, "_rb"}, m_rb, 0);
    chk({tag, "_tw"}, m_tw, 0);
    chk({tag, "_wv"}, m_wv, 0);
    chk({tag, "_wa"}, m_wa, 0);
    chk({tag, "_wb"}, m_wb, 0);
  endtask

  // en_pct: 100 = always enabled, 1..99 = random, <0 = scripted stalls (5 in RUN, 2 in FLUSH).
  task automatic run_xfer(input int which, input int en_pct, input int start_poke,
                          input bit poke_done, input int exp_wall);
    int  idx, w, pos, rdc, wrc, done_wall, bad, ws, stg;
    bit  fin;
    logic en_v, st_v;
    sel = which;
    if (which == 0) build_model(8, 3, 3);
    else            build_model(1024, 10, 3);
    for (int s = 0; s < 10; s++) for (int a = 0; a < 1024; a++) sb[s][a] = 0;
    rdc = 0; wrc = 0; done_wall = -1; idx = 0; w = 0; fin = 1'b0;

    @(posedge clk); #1;
    drive(1'b1, 1'b1);
    @(negedge clk);
    chk("start_cycle_busy", m_busy, 0);

    while (!fin) begin
      @(posedge clk); #1;
      w++;
      if (en_pct >= 100)   en_v = 1'b1;
      else if (en_pct < 0) en_v = !((w >= 3 && w <= 7) || (w >= 11 && w <= 12));
      else                 en_v = ($urandom_range(0, 99) < en_pct);
      st_v = (w == start_poke) || (poke_done && en_v && (idx + 1 == md_total));
      drive(st_v, en_v);
      @(negedge clk);
      pos = idx + 1;
      stg = (pos - 1) / (md_h + md_p);
      if (stg > md_logn - 1) stg = md_logn - 1;
      chk("busy", m_busy, (pos < md_total) ? 1 : 0);
      chk("stage", m_stage, stg);
      chk("done", m_done, (en_v && pos == md_total) ? 1 : 0);
      chk("rd_valid", m_rv, (en_v && exp_rv[pos] == 1) ? 1 : 0);
      if (en_v && exp_rv[pos] == 1) begin
        chk("rd_addr_a", m_ra, exp_ra[pos]);
        chk("rd_addr_b", m_rb, exp_rb[pos]);
        chk("tw_addr", m_tw, exp_tw[pos]);
      end
      chk("wr_valid", m_wv, (en_v && exp_wv[pos] == 1) ? 1 : 0);
      if (en_v && exp_wv[pos] == 1) begin
        chk("wr_addr_a", m_wa, exp_wa[pos]);
        chk("wr_addr_b", m_wb, exp_wb[pos]);
      end
      if (m_rv != 0) rdc++;
      if (m_wv != 0) begin
        wrc++;
        ws = (pos - 1 - md_p) / (md_h + md_p);
        if (pos - 1 - md_p >= 0 && ws < md_logn) begin
          sb[ws][m_wa]++;
          sb[ws][m_wb]++;
        end
      end
      if (m_done != 0 && done_wall < 0) done_wall = w;
      if (en_v) idx = pos;
      if (en_v && pos == md_total) fin = 1'b1;
      if (w > 30000) begin
        chk("timeout", w, 30000);
        break;
      end
    end

    @(posedge clk); #1;
    drive(1'b0, 1'b1);
    @(negedge clk);
    chk("idle_stage", m_stage, 0);
    chk("idle_done", m_done, 0);
    for (int i = 0; i < 4; i++) begin
      chk("no_restart_busy", m_busy, 0);
      chk("no_restart_rv", m_rv, 0);
      @(posedge clk); #1;
      @(negedge clk);
    end
    chk("rd_count", rdc, md_logn * md_h);
    chk("wr_count", wrc, md_logn * md_h);
    if (exp_wall >= 0) chk("done_wall", done_wall, exp_wall);
    bad = 0;
    for (int s = 0; s < md_logn; s++)
      for (int a = 0; a < md_n; a++)
        if (sb[s][a] != 1) bad++;
    chk("write_once_per_stage", bad, 0);
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    sel = 0;
    @(negedge clk);
    chk_zero("reset_small");
    sel = 1;
    chk_zero("reset_big");
    @(posedge clk); #1;
    rst = 1'b0;

    // N=8: clean run, scripted stalls, random enable with stray starts
    run_xfer(0, 100, -1, 1'b0, 22);
    run_xfer(0, -1, -1, 1'b0, 29);
    run_xfer(0, 70, $urandom_range(2, 20), 1'b1, -1);
    run_xfer(0, 50, $urandom_range(2, 20), 1'b1, -1);

    // N=1024: full run with starts in RUN and in DONE
    run_xfer(1, 100, 50, 1'b1, 5151);

    // reset mid-stage-3, with a start coinciding with reset
    sel = 1;
    @(posedge clk); #1;
    drive(1'b1, 1'b1);
    for (int i = 0; i < 1600; i++) begin
      @(posedge clk); #1;
      drive(1'b0, 1'b1);
    end
    @(negedge clk);
    chk("pre_reset_stage", m_stage, 3);
    chk("pre_reset_busy", m_busy, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    drive(1'b1, 1'b1);
    @(negedge clk);
    chk_zero("mid_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1'b0, 1'b1);
    @(negedge clk);
    chk_zero("post_reset");
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("post_reset_wv", m_wv, 0);
      chk("post_reset_rv", m_rv, 0);
      chk("post_reset_busy", m_busy, 0);
    end

    // N=1024 with random enable after the reset
    run_xfer(1, 85, $urandom_range(10, 3000), 1'b1, -1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
